comar_gate_n: RTL and testbench

COMAR_GATE_N -- requirements
Module: comar_gate_n

---
 rtl/comar_pkg.sv | 32 +++
 rtl/comar_lane.sv | 82 ++++++++
 rtl/comar_gate_n.sv | 92 +++++++++
 tb/tb_comar_gate_n.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comar_pkg.sv
// Shared definitions for the first-order masked Boolean gate array:
// operation encoding, share/randomness counts and mode decode helpers.
package comar_pkg;

    localparam int R_PER_LANE = 6;
    localparam int NUM_SHARES = 2;

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_NAND = 3'd1,
        MODE_OR   = 3'd2,
        MODE_NOR  = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_RSV5 = 3'd5,
        MODE_RSV6 = 3'd6,
        MODE_RSV7 = 3'd7
    } comar_mode_e;

    // OR/NOR are built as De Morgan duals of AND on inverted operands.
    function automatic logic mode_inv_in(input comar_mode_e m);
        return (m == MODE_OR) || (m == MODE_NOR);
    endfunction

    function automatic logic mode_inv_out(input comar_mode_e m);
        return (m == MODE_NAND) || (m == MODE_OR);
    endfunction

    function automatic logic mode_reserved(input comar_mode_e m);
        return (m == MODE_RSV5) || (m == MODE_RSV6) || (m == MODE_RSV7);
    endfunction

endpackage

// File: rtl/comar_lane.sv
// One 1-bit lane: stage-1 share refresh registers and stage-2 masked
// partial-product registers. Load strobes come from the shared pipeline control.
module comar_lane
    import comar_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load1,
    input  logic                  load2,
    input  logic                  inv_in,
    input  comar_mode_e           mode1,
    input  comar_mode_e           mode2,
    input  logic                  a_s0,
    input  logic                  a_s1,
    input  logic                  b_s0,
    input  logic                  b_s1,
    input  logic [R_PER_LANE-1:0] r,
    output logic                  c_s0,
    output logic                  c_s1
);

    logic x_s0, x_s1, y_s0, y_s1;
    logic p00, p01, p10, p11, s;
    logic p00_d, p01_d, p10_d, p11_d, s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_s0 <= 1'b0;
            x_s1 <= 1'b0;
            y_s0 <= 1'b0;
            y_s1 <= 1'b0;
        end else if (load1) begin
            x_s0 <= a_s0 ^ r[0] ^ inv_in;
            x_s1 <= a_s1 ^ r[0];
            y_s0 <= b_s0 ^ r[1] ^ inv_in;
            y_s1 <= b_s1 ^ r[1];
        end
    end

    // Each cross product is masked by its own fresh bit before it is stored,
    // so the two shares of x or y never combine ahead of a register.
    always_comb begin
        p00_d = 1'b0;
        p01_d = 1'b0;
        p10_d = 1'b0;
        p11_d = 1'b0;
        s_d   = 1'b0;
        if (!mode_reserved(mode1)) begin
            if (mode1 == MODE_XOR) begin
                p00_d = x_s0 ^ y_s0 ^ r[2];
                s_d   = x_s1 ^ y_s1 ^ r[2];
            end else begin
                p00_d = (x_s0 & y_s0) ^ r[2];
                p01_d = (x_s0 & y_s1) ^ r[3];
                p10_d = (x_s1 & y_s0) ^ r[4];
                p11_d = (x_s1 & y_s1) ^ r[5];
                s_d   = r[2] ^ r[3] ^ r[4] ^ r[5];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p00 <= 1'b0;
            p01 <= 1'b0;
            p10 <= 1'b0;
            p11 <= 1'b0;
            s   <= 1'b0;
        end else if (load2) begin
            p00 <= p00_d;
            p01 <= p01_d;
            p10 <= p10_d;
            p11 <= p11_d;
            s   <= s_d;
        end
    end

    // XOR and reserved beats leave p01..p11 at zero, so one fold serves all modes.
    assign c_s0 = p00 ^ p01 ^ p10 ^ p11 ^ mode_inv_out(mode2);
    assign c_s1 = s;

endmodule

// File: rtl/comar_gate_n.sv
// WIDTH-lane first-order masked AND/NAND/OR/NOR/XOR gate with a two-stage
// valid/ready pipeline (refresh, multiply) and 1 beat/cycle throughput.
module comar_gate_n
    import comar_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SECURITY_ORDER = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  mode,
    input  logic [WIDTH-1:0]            a_s0,
    input  logic [WIDTH-1:0]            a_s1,
    input  logic [WIDTH-1:0]            b_s0,
    input  logic [WIDTH-1:0]            b_s1,
    input  logic [R_PER_LANE*WIDTH-1:0] r,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            c_s0,
    output logic [WIDTH-1:0]            c_s1
);

    generate
        if (SECURITY_ORDER + 1 != NUM_SHARES) begin : g_bad_order
            $error("comar_gate_n: only first-order (two-share) masking is supported");
        end
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("comar_gate_n: WIDTH must be within 1..64");
        end
    endgenerate

    // Handshake: a beat enters when in_valid && in_ready and leaves when
    // out_valid && out_ready. Stage 1 drains into stage 2 when stage 2 is
    // empty or retiring this cycle; in_ready is a function of state and
    // out_ready only, never of in_valid.
    logic        v1, v2;
    logic        accept, adv2;
    comar_mode_e mode_in, mode1, mode2;

    assign mode_in   = comar_mode_e'(mode);
    assign adv2      = v1 & (~v2 | out_ready);
    assign in_ready  = ~v1 | adv2;
    assign accept    = in_valid & in_ready;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            mode1 <= MODE_AND;
            mode2 <= MODE_AND;
        end else begin
            if (accept) begin
                v1    <= 1'b1;
                mode1 <= mode_in;
            end else if (adv2) begin
                v1 <= 1'b0;
            end
            if (adv2) begin
                v2    <= 1'b1;
                mode2 <= mode1;
            end else if (out_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            comar_lane u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .load1  (accept),
                .load2  (adv2),
                .inv_in (mode_inv_in(mode_in)),
                .mode1  (mode1),
                .mode2  (mode2),
                .a_s0   (a_s0[i]),
                .a_s1   (a_s1[i]),
                .b_s0   (b_s0[i]),
                .b_s1   (b_s1[i]),
                .r      (r[R_PER_LANE*i +: R_PER_LANE]),
                .c_s0   (c_s0[i]),
                .c_s1   (c_s1[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_comar_gate_n.sv
// Bench for comar_gate_n: directed and random beats, scoreboard queue with a
// decoupled negedge monitor checking unmasked results and output shares.
module tb_comar_gate_n;
    import comar_pkg::*;

    localparam int W  = 8;
    localparam int RW = R_PER_LANE * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    mode;
    logic [W-1:0]  a_s0, a_s1, b_s0, b_s1;
    logic [RW-1:0] r;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  c_s0, c_s1;

    comar_gate_n #(.WIDTH(W), .SECURITY_ORDER(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .a_s0      (a_s0),
        .a_s1      (a_s1),
        .b_s0      (b_s0),
        .b_s1      (b_s1),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_s0      (c_s0),
        .c_s1      (c_s1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   mode;
        logic [W-1:0] c;
        logic [W-1:0] a_s1;
        logic [W-1:0] b_s1;
        int           acc_edge;
        bit           chk_lat;
    } item_t;

    item_t         exp_q[$];
    logic [RW-1:0] r_hist[int];
    int            cyc = 0;
    int            last_retire = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            rand_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Fresh randomness every cycle; random backpressure when enabled.
    always @(posedge clk) begin
        #1;
        r = RW'({$urandom(), $urandom()});
        if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [2:0] m, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (m)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit lat);
        item_t it;
        int    waited;
        waited = 0;
        mode = m;
        a_s0 = W'($urandom());
        a_s1 = a ^ a_s0;
        b_s0 = W'($urandom());
        b_s1 = b ^ b_s0;
        in_valid = 1'b1;
        it.mode = m;
        it.c = model(m, a, b);
        it.a_s1 = a_s1;
        it.b_s1 = b_s1;
        it.chk_lat = lat;
        it.acc_edge = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                it.acc_edge = cyc + 1;
                exp_q.push_back(it);
                break;
            end
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 64'(0), 64'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        item_t         it;
        int            ret, tr;
        logic [RW-1:0] ra, rt;
        logic [W-1:0]  exp_s1;
        if (rst_n) begin
            r_hist[cyc + 1] = r;
            if (out_valid && out_ready) begin
                ret = cyc + 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    it = exp_q.pop_front();
                    // A beat moves to stage 2 one edge after acceptance, or when
                    // the beat ahead of it retires, whichever is later.
                    tr = (it.acc_edge + 1 > last_retire) ? it.acc_edge + 1 : last_retire;
                    ra = r_hist[it.acc_edge];
                    rt = r_hist[tr];
                    for (int i = 0; i < W; i++) begin
                        if (it.mode == 3'd4)
                            exp_s1[i] = it.a_s1[i] ^ it.b_s1[i] ^ ra[6*i] ^ ra[6*i+1] ^ rt[6*i+2];
                        else if (it.mode > 3'd4)
                            exp_s1[i] = 1'b0;
                        else
                            exp_s1[i] = rt[6*i+2] ^ rt[6*i+3] ^ rt[6*i+4] ^ rt[6*i+5];
                    end
                    check("c_unmasked", 64'(c_s0 ^ c_s1), 64'(it.c));
                    check("c_s1_share", 64'(c_s1), 64'(exp_s1));
                    if (it.chk_lat) check("latency", 64'(ret - it.acc_edge), 64'(2));
                    last_retire = ret;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [2:0]   m;
        logic [W-1:0] h0, h1;
        mode = '0; a_s0 = '0; a_s1 = '0; b_s0 = '0; b_s1 = '0; r = '0;
        in_valid = 1'b0; out_ready = 1'b0;

        #2;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_c_s0", 64'(c_s0), 64'(0));
        check("reset_c_s1", 64'(c_s1), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;

        send(3'd3, 8'h0F, 8'h33, 1'b1);
        drain();

        send(3'd0, 8'hA5, 8'h3C, 1'b1);
        send(3'd1, 8'hA5, 8'h3C, 1'b1);
        send(3'd2, 8'hA5, 8'h3C, 1'b1);
        send(3'd4, 8'hA5, 8'h3C, 1'b1);
        drain();

        send(3'd6, 8'hFF, 8'hFF, 1'b1);
        drain();

        // Backpressure: five beats against three cycles of out_ready low.
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(3'($urandom_range(0, 4)), W'($urandom()), W'($urandom()), 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                check("in_ready_low_when_full", 64'(in_ready), 64'(0));
                check("out_valid_in_stall", 64'(out_valid), 64'(1));
                h0 = c_s0;
                h1 = c_s1;
                @(posedge clk);
                #1;
                check("stall_hold_c_s0", 64'(c_s0), 64'(h0));
                check("stall_hold_c_s1", 64'(c_s1), 64'(h1));
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(3'd0, W'($urandom()), W'($urandom()), 1'b0);
        send(3'd4, W'($urandom()), W'($urandom()), 1'b0);
        @(negedge clk);
        check("full_before_reset", 64'({out_valid, in_ready}), 64'(2'b10));
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'(0));
        check("async_reset_c_s0", 64'(c_s0), 64'(0));
        check("async_reset_c_s1", 64'(c_s1), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_stale_beat", 64'(out_valid), 64'(0));
        end
        check("in_ready_post_reset", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Random traffic with random stalls and idle gaps.
        rand_stall = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            m = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            send(m, W'($urandom()), W'($urandom()), 1'b0);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        rand_stall = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, actual running required done");
        $fatal(1);
    end

endmodule
